// File: rtl/z80_bus_responder.sv
// Memory/IO responder for the tv80s bus: serves CPU reads and writes from an
// internal RAM with optional wait states, answers INTA with a fixed vector, and exposes a backdoor port.
module z80_bus_responder #(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  IO_PAGE     = 8'h10,
    parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        dout,
    output logic [7:0]        di,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    output logic              wait_n,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
    output logic              bd_drop,
    output logic [15:0]       wr_count,
    output logic [ADDR_W-1:0] last_wr_addr,
    output logic [7:0]        last_wr_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACT, S_DONE} state_t;
    typedef enum logic [2:0] {C_NONE, C_INTA, C_IORD, C_IOWR, C_MRD, C_MWR} cls_t;

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    cls_t              cls;
    cls_t              req_cls;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       io_full;
    logic [7:0]        rd_latch;
    logic              cls_is_write;
    logic              bd_ok;
    logic              cpu_we;

    logic [7:0] mem [2**ADDR_W];

    // Request decode in priority order; refresh cycles never qualify.
    always_comb begin
        req_cls = C_NONE;
        if (!m1_n && !iorq_n)
            req_cls = C_INTA;
        else if (!iorq_n && !rd_n)
            req_cls = C_IORD;
        else if (!iorq_n && !wr_n)
            req_cls = C_IOWR;
        else if (!mreq_n && rfsh_n && !rd_n)
            req_cls = C_MRD;
        else if (!mreq_n && rfsh_n && !wr_n)
            req_cls = C_MWR;
    end

    assign io_full  = {IO_PAGE, A[7:0]};
    assign req_addr = (req_cls == C_IORD || req_cls == C_IOWR) ? io_full[ADDR_W-1:0]
                                                                 : A[ADDR_W-1:0];

    assign cls_is_write = (cls == C_IOWR) || (cls == C_MWR);
    assign bd_ok        = (state == S_IDLE) && (req_cls == C_NONE) && !reset;
    assign cpu_we       = (state == S_ACT) && cls_is_write && !reset;

    // RAM: CPU commit (ACT) and backdoor commit (quiet IDLE) are mutually exclusive.
    always_ff @(posedge clk) begin
        if (cpu_we)
            mem[addr] <= dout;
        else if (bd_we && bd_ok)
            mem[bd_addr] <= bd_wdata;
        if (state == S_IDLE && req_cls != C_NONE && req_cls != C_INTA)
            rd_latch <= mem[req_addr];
    end

    always_ff @(posedge clk) begin
        if (reset)
            bd_rdata <= 8'h00;
        else
            bd_rdata <= mem[bd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cls          <= C_NONE;
            cnt          <= 4'd0;
            addr         <= '0;
            wait_n       <= 1'b1;
            di           <= 8'hFF;
            bd_drop      <= 1'b0;
            wr_count     <= 16'h0000;
            last_wr_addr <= '0;
            last_wr_data <= 8'h00;
        end else begin
            bd_drop <= bd_we && !bd_ok;
            case (state)
                S_IDLE: begin
                    if (req_cls != C_NONE) begin
                        cls  <= req_cls;
                        addr <= req_addr;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACT;
                        end else begin
                            state  <= S_WAIT;
                            wait_n <= 1'b0;
                            cnt    <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= S_ACT;
                        wait_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACT: begin
                    case (cls)
                        C_INTA:        di <= INT_VECTOR;
                        C_IORD, C_MRD: di <= rd_latch;
                        C_IOWR, C_MWR: begin
                            wr_count     <= wr_count + 16'd1;
                            last_wr_addr <= addr;
                            last_wr_data <= dout;
                        end
                        default: ;
                    endcase
                    state <= S_DONE;
                end
                S_DONE: begin
                    // Hold di until the CPU has released both strobes.
                    if (mreq_n && iorq_n)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder with two wait states per access.
module tb_z80_bus_responder;

    localparam int K_IDLE = 0, K_MRD = 1, K_MWR = 2, K_IORD = 3, K_IOWR = 4, K_INTA = 5, K_RFSH = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  dout, di;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, wait_n;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_wdata, bd_rdata;
    logic        bd_drop;
    logic [15:0] wr_count, last_wr_addr;
    logic [7:0]  last_wr_data;

    int tests = 0;
    int fails = 0;

    z80_bus_responder #(
        .ADDR_W(16), .WAIT_STATES(2), .IO_PAGE(8'h10), .INT_VECTOR(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .A(A), .dout(dout), .di(di),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rfsh_n(rfsh_n), .wait_n(wait_n), .bd_we(bd_we), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .bd_drop(bd_drop),
        .wr_count(wr_count), .last_wr_addr(last_wr_addr), .last_wr_data(last_wr_data)
    );

    always #5 clk = ~clk;

    task automatic drive(input int kind);
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        case (kind)
            K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
            K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_INTA: begin m1_n = 1'b0; iorq_n = 1'b0; end
            K_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            default: ;
        endcase
    endtask

    // Holds the strobes for six cycles, counting wait_n lows; di_pre is sampled before the ACT edge.
    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                             output int wait_lows, output logic [7:0] di_pre, output logic [7:0] di_act);
        @(negedge clk);
        A = addr; dout = data; drive(kind);
        wait_lows = 0; di_pre = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wait_n === 1'b0) wait_lows++;
            if (i == 2) di_pre = di;
        end
        di_act = di;
        drive(K_IDLE);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [7:0] d, output logic drop);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(negedge clk);
        drop = bd_drop;
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bd_addr = a;
        @(negedge clk);
        d = bd_rdata;
    endtask

    task automatic test_reset;
        reset = 1'b1; bd_we = 1'b0; bd_addr = 16'h0000; bd_wdata = 8'h00;
        A = 16'h0000; dout = 8'h00; drive(K_IDLE);
        repeat (2) @(negedge clk);
        tests++; if (di !== 8'hFF) begin fails++; $display("FAIL reset_di: got %h want ff", di); end
        tests++; if (wait_n !== 1'b1) begin fails++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
        tests++; if (bd_rdata !== 8'h00) begin fails++; $display("FAIL reset_bd_rdata: got %h want 00", bd_rdata); end
        tests++; if (bd_drop !== 1'b0) begin fails++; $display("FAIL reset_bd_drop: got %b want 0", bd_drop); end
        tests++; if (wr_count !== 16'h0000) begin fails++; $display("FAIL reset_wr_count: got %h want 0000", wr_count); end
        tests++; if (last_wr_addr !== 16'h0000) begin fails++; $display("FAIL reset_last_addr: got %h want 0000", last_wr_addr); end
        tests++; if (last_wr_data !== 8'h00) begin fails++; $display("FAIL reset_last_data: got %h want 00", last_wr_data); end
        reset = 1'b0;
    endtask

    task automatic test_mem_write;
        logic drop; logic [7:0] rd, dp, da; int wl;
        bd_write(16'h7EA7, 8'h45, drop);
        tests++; if (drop !== 1'b0) begin fails++; $display("FAIL bd_accept_drop: got %b want 0", drop); end
        bd_read(16'h7EA7, rd);
        tests++; if (rd !== 8'h45) begin fails++; $display("FAIL bd_preload: got %h want 45", rd); end
        bus_cycle(K_MWR, 16'h7EA7, 8'h4D, wl, dp, da);
        tests++; if (wl != 2) begin fails++; $display("FAIL mwr_wait_cycles: got %0d want 2", wl); end
        bd_read(16'h7EA7, rd);
        tests++; if (rd !== 8'h4D) begin fails++; $display("FAIL mwr_ram: got %h want 4d", rd); end
        tests++; if (wr_count !== 16'h0001) begin fails++; $display("FAIL mwr_count: got %h want 0001", wr_count); end
        tests++; if (last_wr_addr !== 16'h7EA7) begin fails++; $display("FAIL mwr_last_addr: got %h want 7ea7", last_wr_addr); end
        tests++; if (last_wr_data !== 8'h4D) begin fails++; $display("FAIL mwr_last_data: got %h want 4d", last_wr_data); end
    endtask

    task automatic test_mem_read_wait;
        logic drop; logic [7:0] dp, da; int wl;
        bd_write(16'h0003, 8'hDC, drop);
        bus_cycle(K_MRD, 16'h0003, 8'h00, wl, dp, da);
        tests++; if (wl != 2) begin fails++; $display("FAIL mrd_wait_cycles: got %0d want 2", wl); end
        tests++; if (dp !== 8'hFF) begin fails++; $display("FAIL mrd_di_before_act: got %h want ff", dp); end
        tests++; if (da !== 8'hDC) begin fails++; $display("FAIL mrd_di_done: got %h want dc", da); end
        tests++; if (di !== 8'hDC) begin fails++; $display("FAIL mrd_di_held: got %h want dc", di); end
    endtask

    task automatic test_refresh;
        logic drop; logic [7:0] rd, dp, da; int wl;
        bd_write(16'h0042, 8'h77, drop);
        bus_cycle(K_RFSH, 16'h0042, 8'h13, wl, dp, da);
        tests++; if (wl != 0) begin fails++; $display("FAIL rfsh_wait_cycles: got %0d want 0", wl); end
        bd_read(16'h0042, rd);
        tests++; if (rd !== 8'h77) begin fails++; $display("FAIL rfsh_ram: got %h want 77", rd); end
        tests++; if (wr_count !== 16'h0001) begin fails++; $display("FAIL rfsh_count: got %h want 0001", wr_count); end
        tests++; if (di !== 8'hDC) begin fails++; $display("FAIL rfsh_di: got %h want dc", di); end
    endtask

    task automatic test_io_inta;
        logic drop; logic [7:0] rd, dp, da; int wl;
        bd_write(16'hAB34, 8'h11, drop);
        bus_cycle(K_IOWR, 16'hAB34, 8'hA5, wl, dp, da);
        tests++; if (wl != 2) begin fails++; $display("FAIL iowr_wait_cycles: got %0d want 2", wl); end
        bd_read(16'h1034, rd);
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL iowr_ram: got %h want a5", rd); end
        bd_read(16'hAB34, rd);
        tests++; if (rd !== 8'h11) begin fails++; $display("FAIL iowr_mem_alias: got %h want 11", rd); end
        tests++; if (wr_count !== 16'h0002) begin fails++; $display("FAIL iowr_count: got %h want 0002", wr_count); end
        tests++; if (last_wr_addr !== 16'h1034) begin fails++; $display("FAIL iowr_last_addr: got %h want 1034", last_wr_addr); end
        bus_cycle(K_IORD, 16'h0034, 8'h00, wl, dp, da);
        tests++; if (dp !== 8'hDC) begin fails++; $display("FAIL iord_di_before_act: got %h want dc", dp); end
        tests++; if (da !== 8'hA5) begin fails++; $display("FAIL iord_di: got %h want a5", da); end
        bus_cycle(K_INTA, 16'h1034, 8'h5E, wl, dp, da);
        tests++; if (da !== 8'hFF) begin fails++; $display("FAIL inta_di: got %h want ff", da); end
        bd_read(16'h1034, rd);
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL inta_ram: got %h want a5", rd); end
        tests++; if (wr_count !== 16'h0002) begin fails++; $display("FAIL inta_count: got %h want 0002", wr_count); end
    endtask

    task automatic test_reset_mid;
        logic drop; logic [7:0] rd;
        bd_write(16'h2222, 8'h5A, drop);
        @(negedge clk);
        A = 16'h2222; dout = 8'h99; drive(K_MWR);
        @(negedge clk);
        tests++; if (wait_n !== 1'b0) begin fails++; $display("FAIL midrst_in_wait: got %b want 0", wait_n); end
        reset = 1'b1; drive(K_IDLE);
        @(negedge clk);
        tests++; if (wait_n !== 1'b1) begin fails++; $display("FAIL midrst_wait_n: got %b want 1", wait_n); end
        tests++; if (wr_count !== 16'h0000) begin fails++; $display("FAIL midrst_count: got %h want 0000", wr_count); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        bd_read(16'h2222, rd);
        tests++; if (rd !== 8'h5A) begin fails++; $display("FAIL midrst_ram: got %h want 5a", rd); end
    endtask

    task automatic test_bd_drop;
        logic drop; logic [7:0] rd;
        bd_write(16'h0050, 8'h33, drop);
        @(negedge clk);
        A = 16'h0003; drive(K_MRD);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 16'h0050; bd_wdata = 8'hEE;
        @(negedge clk);
        tests++; if (bd_drop !== 1'b1) begin fails++; $display("FAIL bd_drop_pulse: got %b want 1", bd_drop); end
        bd_we = 1'b0;
        @(negedge clk);
        tests++; if (bd_drop !== 1'b0) begin fails++; $display("FAIL bd_drop_clear: got %b want 0", bd_drop); end
        repeat (4) @(negedge clk);
        tests++; if (di !== 8'hDC) begin fails++; $display("FAIL bd_drop_mrd_di: got %h want dc", di); end
        drive(K_IDLE);
        repeat (2) @(negedge clk);
        bd_read(16'h0050, rd);
        tests++; if (rd !== 8'h33) begin fails++; $display("FAIL bd_drop_ram: got %h want 33", rd); end
    endtask

    task automatic test_wr_count_wrap;
        logic [7:0] dp, da; int wl;
        @(negedge clk);
        force dut.wr_count = 16'hFFFF;
        #1;
        release dut.wr_count;
        bus_cycle(K_MWR, 16'h0100, 8'h3C, wl, dp, da);
        tests++; if (wr_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", wr_count); end
        tests++; if (last_wr_addr !== 16'h0100) begin fails++; $display("FAIL wrap_last_addr: got %h want 0100", last_wr_addr); end
        tests++; if (last_wr_data !== 8'h3C) begin fails++; $display("FAIL wrap_last_data: got %h want 3c", last_wr_data); end
    endtask

    initial begin
        test_reset;
        test_mem_write;
        test_mem_read_wait;
        test_refresh;
        test_io_inta;
        test_reset_mid;
        test_bd_drop;
        test_wr_count_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
